waveform_gen_mc: RTL and testbench

Multi-channel, parametrised NeoPixel waveform generator. It serialises CH_NUM independent pixel-word streams, MSB first, into T0H/T0L/T1H/T1L-coded line waveforms, one output pin per channel. After a word flagged last, it inserts a programmable reset/latch gap. It sits between the per-channel pixel FIFOs and the LED output pins, and uses one shared set of timing registers.

---
 rtl/waveform_pkg.sv | 18 +
 rtl/waveform_chan.sv | 144 ++++++++++++++
 rtl/waveform_gen_mc.sv | 48 ++++
 tb/tb_waveform_gen_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
// Shared types and default line timings for the multi-channel NeoPixel waveform generator.
package waveform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_RST  = 2'd3
  } wave_state_e;

  // Phase lengths in cycles of a 50 MHz clock
  localparam int DEF_T0H = 20;
  localparam int DEF_T0L = 43;
  localparam int DEF_T1H = 40;
  localparam int DEF_T1L = 23;
  localparam int DEF_RST = 2500;

endpackage

// File: rtl/waveform_chan.sv
// One output channel: captures a pixel word with a timing snapshot and serialises it
// MSB first as HIGH/LOW phase pairs, followed by a latch gap after a last word.
module waveform_chan
  import waveform_pkg::*;
#(
  parameter int DW = 24,
  parameter int TW = 8,
  parameter int RW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          word_vld_i,
  input  logic [DW-1:0] word_data_i,
  input  logic          word_last_i,
  output logic          word_rdy_o,
  input  logic [TW-1:0] reg_t0h_time_i,
  input  logic [TW-1:0] reg_t0l_time_i,
  input  logic [TW-1:0] reg_t1h_time_i,
  input  logic [TW-1:0] reg_t1l_time_i,
  input  logic [RW-1:0] reg_rst_time_i,
  output logic          busy_o,
  output logic          code_o
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  wave_state_e   state_q, state_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          last_q;
  logic [TW-1:0] t0h_q, t0l_q, t1h_q, t1l_q;
  logic [RW-1:0] trst_q;
  logic [TW-1:0] h_lim, l_lim;
  logic [RW-1:0] r_lim;
  logic          h_done, l_done, r_done;
  logic          acc;

  // A programmed zero behaves as a one-cycle phase
  always_comb begin
    h_lim = sreg_q[DW-1] ? t1h_q : t0h_q;
    l_lim = sreg_q[DW-1] ? t1l_q : t0l_q;
    r_lim = trst_q;
    if (h_lim == '0) h_lim = TW'(1);
    if (l_lim == '0) l_lim = TW'(1);
    if (r_lim == '0) r_lim = RW'(1);
  end

  assign h_done = (cnt_q >= h_lim);
  assign l_done = (cnt_q >= l_lim);
  assign r_done = (rcnt_q >= r_lim);

  // Ready in the final LOW cycle of a non-last word lets the next word chain seamlessly
  assign word_rdy_o = !rst_i &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_LOW) && l_done && (bidx_q == '0) && !last_q));
  assign acc    = word_vld_i && word_rdy_o;
  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bidx_d  = bidx_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (h_done) begin
          state_d = ST_LOW;
          cnt_d   = TW'(1);
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (l_done) begin
          if (bidx_q != '0) begin
            state_d = ST_HIGH;
            sreg_d  = {sreg_q[DW-2:0], 1'b0};
            bidx_d  = bidx_q - 1'b1;
            cnt_d   = TW'(1);
          end else if (last_q) begin
            state_d = ST_RST;
            cnt_d   = '0;
            rcnt_d  = RW'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
      end
      ST_RST: begin
        rcnt_d = rcnt_q + 1'b1;
        if (r_done) begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (acc) begin
      state_d = ST_HIGH;
      sreg_d  = word_data_i;
      bidx_d  = BW'(DW-1);
      cnt_d   = TW'(1);
      rcnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bidx_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      last_q  <= 1'b0;
      t0h_q   <= '0;
      t0l_q   <= '0;
      t1h_q   <= '0;
      t1l_q   <= '0;
      trst_q  <= '0;
      code_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      code_o  <= (state_d == ST_HIGH);
      if (acc) begin
        last_q <= word_last_i;
        t0h_q  <= reg_t0h_time_i;
        t0l_q  <= reg_t0l_time_i;
        t1h_q  <= reg_t1h_time_i;
        t1l_q  <= reg_t1l_time_i;
        trst_q <= reg_rst_time_i;
      end
    end
  end

endmodule

// File: rtl/waveform_gen_mc.sv
// Multi-channel NeoPixel waveform generator: CH_NUM independent serialisers sharing
// one set of timing registers.
module waveform_gen_mc
  import waveform_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DW     = 24,
  parameter int TW     = 8,
  parameter int RW     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CH_NUM-1:0]          word_vld_i,
  input  logic [CH_NUM-1:0][DW-1:0]  word_data_i,
  input  logic [CH_NUM-1:0]          word_last_i,
  output logic [CH_NUM-1:0]          word_rdy_o,
  input  logic [TW-1:0]              reg_t0h_time_i,
  input  logic [TW-1:0]              reg_t0l_time_i,
  input  logic [TW-1:0]              reg_t1h_time_i,
  input  logic [TW-1:0]              reg_t1l_time_i,
  input  logic [RW-1:0]              reg_rst_time_i,
  output logic [CH_NUM-1:0]          busy_o,
  output logic [CH_NUM-1:0]          code_o
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    waveform_chan #(
      .DW (DW),
      .TW (TW),
      .RW (RW)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .word_vld_i     (word_vld_i[i]),
      .word_data_i    (word_data_i[i]),
      .word_last_i    (word_last_i[i]),
      .word_rdy_o     (word_rdy_o[i]),
      .reg_t0h_time_i (reg_t0h_time_i),
      .reg_t0l_time_i (reg_t0l_time_i),
      .reg_t1h_time_i (reg_t1h_time_i),
      .reg_t1l_time_i (reg_t1l_time_i),
      .reg_rst_time_i (reg_rst_time_i),
      .busy_o         (busy_o[i]),
      .code_o         (code_o[i])
    );
  end

endmodule

// File: tb/tb_waveform_gen_mc.sv
// Bench for waveform_gen_mc: a per-channel queue of expected {code,busy,rdy} cycles is
// built from each accepted word and compared against the DUT on every cycle.
module tb_waveform_gen_mc;
  localparam int CH = 4, DW = 24, TW = 8, RW = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [CH-1:0]          vld = '0, last = '0;
  logic [CH-1:0][DW-1:0]  data = '0;
  logic [CH-1:0]          rdy, busy, code;
  logic [TW-1:0]          t0h = 8'd2, t0l = 8'd3, t1h = 8'd4, t1l = 8'd1;
  logic [RW-1:0]          trst = 16'd10;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int unsigned   start;
  } word_t;

  word_t       stim_q [CH][$];
  logic [2:0]  exp_q  [CH][$];   // {code, busy, rdy} per future cycle
  int unsigned cyc = 0;
  int          errors = 0, checks = 0;
  bit          chk_en = 1'b0;
  bit          acc_seen [CH];
  int          busy_cnt [CH], hi_cnt [CH];
  bit          m_rdy, m_acc;
  logic [2:0]  e;

  waveform_gen_mc #(.CH_NUM(CH), .DW(DW), .TW(TW), .RW(RW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .word_vld_i     (vld),
    .word_data_i    (data),
    .word_last_i    (last),
    .word_rdy_o     (rdy),
    .reg_t0h_time_i (t0h),
    .reg_t0l_time_i (t0l),
    .reg_t1h_time_i (t1h),
    .reg_t1l_time_i (t1l),
    .reg_rst_time_i (trst),
    .busy_o         (busy),
    .code_o         (code)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic int mx(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Whole waveform of one word, in cycles, from the timing snapshot taken at acceptance
  task automatic push_word(int c, logic [DW-1:0] d, logic l);
    int h, lo;
    for (int b = DW - 1; b >= 0; b--) begin
      h  = d[b] ? mx(int'(t1h)) : mx(int'(t0h));
      lo = d[b] ? mx(int'(t1l)) : mx(int'(t0l));
      for (int j = 0; j < h; j++) exp_q[c].push_back(3'b110);
      for (int j = 0; j < lo; j++)
        exp_q[c].push_back({2'b01, (b == 0) && (j == lo - 1) && !l});
    end
    if (l) for (int j = 0; j < mx(int'(trst)); j++) exp_q[c].push_back(3'b010);
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      m_rdy = (exp_q[c].size() == 0) ? 1'b1 : exp_q[c][0][0];
      m_acc = vld[c] && m_rdy && !rst;
      if (exp_q[c].size() != 0) void'(exp_q[c].pop_front());
      if (rst) exp_q[c].delete();
      if (m_acc) begin
        push_word(c, data[c], last[c]);
        void'(stim_q[c].pop_front());
        acc_seen[c] = 1'b1;
      end
    end
    cyc++;
    #1;
    for (int c = 0; c < CH; c++) begin
      if (stim_q[c].size() != 0 && cyc >= stim_q[c][0].start) begin
        vld[c]  = 1'b1;
        data[c] = stim_q[c][0].d;
        last[c] = stim_q[c][0].l;
      end else begin
        vld[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        e = (exp_q[c].size() != 0) ? exp_q[c][0] : 3'b001;
        chk($sformatf("code[%0d]", c), 32'(code[c]), 32'(e[2]));
        chk($sformatf("busy[%0d]", c), 32'(busy[c]), 32'(e[1]));
        chk($sformatf("rdy[%0d]", c),  32'(rdy[c]),  32'(e[0] && !rst));
        busy_cnt[c] += int'(busy[c]);
        hi_cnt[c]   += int'(code[c]);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_t(int a, int b, int c, int d, int r);
    t0h = TW'(a); t0l = TW'(b); t1h = TW'(c); t1l = TW'(d); trst = RW'(r);
  endtask

  task automatic clr_meas();
    for (int c = 0; c < CH; c++) begin
      busy_cnt[c] = 0; hi_cnt[c] = 0; acc_seen[c] = 1'b0;
    end
  endtask

  task automatic push(int c, logic [DW-1:0] d, logic l, int unsigned off);
    word_t w;
    w.d = d; w.l = l; w.start = cyc + off;
    stim_q[c].push_back(w);
  endtask

  function automatic bit pending();
    for (int c = 0; c < CH; c++)
      if (exp_q[c].size() != 0 || stim_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    while (n < budget && pending()) begin tick(1); n++; end
    chk({nm, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    // reset state
    tick(2);
    chk_en = 1'b1;
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdy",  32'(rdy),  32'h0);
    rst = 1'b0;
    tick(1);
    chk("idle_rdy", 32'(rdy), 32'hF);

    // single word, last
    clr_meas(); set_t(2, 3, 4, 1, 10);
    push(0, 24'h800000, 1'b1, 0);
    tick(3);
    chk("t1_model_len", 32'(exp_q[0].size()), 32'd129);
    wait_idle("t1", 400);
    chk("t1_busy", 32'(busy_cnt[0]), 32'd130);
    chk("t1_hi",   32'(hi_cnt[0]),   32'd50);

    // two chained words with vld held
    clr_meas();
    push(1, 24'hA5A5A5, 1'b0, 0);
    push(1, 24'h0F0F0F, 1'b1, 0);
    wait_idle("t2", 600);
    chk("t2_busy", 32'(busy_cnt[1]), 32'd250);
    chk("t2_hi",   32'(hi_cnt[1]),   32'd144);

    // zero timing everywhere
    clr_meas(); set_t(0, 0, 0, 0, 0);
    push(2, 24'h123456, 1'b1, 0);
    wait_idle("t3", 200);
    chk("t3_busy", 32'(busy_cnt[2]), 32'd49);
    chk("t3_hi",   32'(hi_cnt[2]),   32'd24);

    // timing change after acceptance only affects the next word
    clr_meas(); set_t(2, 3, 4, 1, 10);
    push(3, 24'hFFFFFF, 1'b0, 0);
    push(3, 24'hFFFFFF, 1'b1, 0);
    n = 0;
    while (!acc_seen[3] && n < 50) begin tick(1); n++; end
    chk("t4_acc", 32'(acc_seen[3]), 32'd1);
    tick(5);
    t1h = 8'd8;
    wait_idle("t4", 800);
    chk("t4_busy", 32'(busy_cnt[3]), 32'd346);
    chk("t4_hi",   32'(hi_cnt[3]),   32'd288);

    // all channels, staggered starts
    clr_meas(); set_t(2, 3, 4, 1, 10);
    push(0, 24'hC3A501, 1'b0, 0);
    push(1, 24'hFFFFFF, 1'b1, 3);
    push(2, 24'h000000, 1'b1, 7);
    push(3, 24'h5A5A5A, 1'b1, 12);
    wait_idle("t5", 600);
    chk("t5_busy0", 32'(busy_cnt[0]), 32'd120);
    chk("t5_busy1", 32'(busy_cnt[1]), 32'd130);
    chk("t5_hi1",   32'(hi_cnt[1]),   32'd96);
    chk("t5_busy2", 32'(busy_cnt[2]), 32'd130);
    chk("t5_hi2",   32'(hi_cnt[2]),   32'd48);

    // reset during HIGH of bit 10, then a fresh word
    clr_meas();
    push(0, 24'hFFFFFF, 1'b1, 0);
    n = 0;
    while (!acc_seen[0] && n < 50) begin tick(1); n++; end
    chk("t6_acc", 32'(acc_seen[0]), 32'd1);
    tick(66);
    chk("t6_pre_code", 32'(code[0]), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6_code", 32'(code[0]), 32'd0);
    chk("t6_busy", 32'(busy[0]), 32'd0);
    chk("t6_rdy",  32'(rdy),     32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t6_rdy_back", 32'(rdy), 32'hF);
    clr_meas();
    push(0, 24'h800000, 1'b1, 0);
    wait_idle("t6", 400);
    chk("t6_busy2", 32'(busy_cnt[0]), 32'd130);
    chk("t6_hi2",   32'(hi_cnt[0]),   32'd50);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
